// File: rtl/rram_seq_pkg.sv
// Shared types for the RRAM command sequencer.
// Op codes, FSM states, register offsets, lane helpers.
package rram_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_MAC   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_TIMING = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;

  function automatic logic [31:0] lane_mask(
    input logic [3:0] sel
  );
    return {{8{sel[3]}}, {8{sel[2]}},
            {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [1:0] onehot2(
    input logic b
  );
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rram_wb_regs.sv
// Wishbone slave decode, ack and register file.
// RRAM_SEQ_IRQ_EN adds the CTRL[9] irq-enable bit.
module rram_wb_regs
  import rram_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             busy,
  input  logic             capture,
  input  logic [3:0]       cap_code,
  input  logic             done_evt,
  output op_e              op,
  output logic             row,
  output logic             col,
  output logic [CNT_W-1:0] pulse,
  output logic             start,
  output logic             irq
);

  logic        hit;
  logic        req;
  logic        wr;
  logic [7:0]  off;
  logic [31:0] m;
  logic        sel_ctrl;
  logic        sel_tim;
  logic        sel_stat;
  logic        sel_res;
  logic [31:0] ctrl_rd;
  logic [31:0] tim_rd;
  logic [31:0] stat_rd;
  logic [31:0] res_rd;
  logic [31:0] ctrl_nv;
  logic [31:0] tim_nv;
  logic [31:0] clr;
  logic [31:0] rdata;
  logic        irq_en;
  logic        done_q;
  logic        err_q;
  logic [3:0]  code_q;
  logic [15:0] seq_q;
  logic        unused_ok;

  assign hit = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr  = req & wbs_we_i;
  assign off = wbs_adr_i[7:0];
  assign m   = lane_mask(wbs_sel_i);

  assign sel_ctrl = off == OFF_CTRL;
  assign sel_tim  = off == OFF_TIMING;
  assign sel_stat = off == OFF_STATUS;
  assign sel_res  = off == OFF_RESULT;

  assign ctrl_rd = {22'b0, irq_en, 1'b0, 4'b0,
                    col, row, op};
  assign tim_rd  = 32'(pulse);
  assign stat_rd = {29'b0, err_q, done_q, busy};
  assign res_rd  = {seq_q, 12'b0, code_q};

  assign ctrl_nv = (ctrl_rd & ~m) | (wbs_dat_i & m);
  assign tim_nv  = (tim_rd & ~m) | (wbs_dat_i & m);
  assign clr     = wbs_dat_i & m;

  assign start = wr & sel_ctrl & clr[8] & ~busy;

  assign unused_ok = ^{ctrl_nv, tim_nv, clr};

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = ctrl_rd;
      sel_tim:  rdata = tim_rd;
      sel_stat: rdata = stat_rd;
      sel_res:  rdata = res_rd;
      default:  rdata = '0;
    endcase
  end

  // Single-cycle ack with read data captured at request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
    end
  end

  // CTRL and TIMING fields, frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      op    <= OP_READ;
      row   <= 1'b0;
      col   <= 1'b0;
      pulse <= CNT_W'(1);
    end else begin
      if (wr & sel_ctrl & ~busy) begin
        op  <= op_e'(ctrl_nv[1:0]);
        row <= ctrl_nv[2];
        col <= ctrl_nv[3];
      end
      if (wr & sel_tim & ~busy)
        pulse <= tim_nv[CNT_W-1:0];
    end
  end

`ifdef RRAM_SEQ_IRQ_EN
  // Interrupt enable bit and level interrupt.
  always_ff @(posedge clk) begin
    if (rst)
      irq_en <= 1'b0;
    else if (wr & sel_ctrl & ~busy)
      irq_en <= ctrl_nv[9];
  end

  assign irq = done_q & irq_en;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // STATUS flags, RESULT code and sequence count.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= '0;
      seq_q  <= '0;
    end else begin
      if (wr & (sel_ctrl | sel_tim) & busy)
        err_q <= 1'b1;
      if (wr & sel_stat) begin
        if (clr[1]) done_q <= 1'b0;
        if (clr[2]) err_q  <= 1'b0;
      end
      if (start)
        done_q <= 1'b0;
      if (done_evt) begin
        done_q <= 1'b1;
        seq_q  <= seq_q + 16'd1;
      end
      if (capture)
        code_q <= cap_code;
    end
  end

endmodule

// File: rtl/rram_wb_seq.sv
// Wishbone command sequencer for the 2x2 RRAM macro.
// Optional irq via RRAM_SEQ_IRQ_EN.
module rram_wb_seq
  import rram_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          SETUP_CYC  = 4,
  parameter int          SETTLE_CYC = 8,
  parameter int          CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [1:0]  wl_en,
  output logic [1:0]  bl_en,
  output logic [1:0]  sl_en,
  output logic        pre_en,
  output logic        adc_smp,
  input  logic [3:0]  adc_code,
  output logic        busy,
  output logic        irq
);

  localparam logic [CNT_W-1:0] SETUP_LD  =
    CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] pulse;
  logic [CNT_W-1:0] pulse_ld;
  op_e              op;
  logic             row;
  logic             col;
  logic             start;
  logic             rd_op;
  logic             active;
  logic             capture;
  logic             done_evt;
  logic [1:0]       col_oh;

  rram_wb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .busy      (busy),
    .capture   (capture),
    .cap_code  (adc_code),
    .done_evt  (done_evt),
    .op        (op),
    .row       (row),
    .col       (col),
    .pulse     (pulse),
    .start     (start),
    .irq       (irq)
  );

  assign busy     = state_q != ST_IDLE;
  assign rd_op    = (op == OP_READ) || (op == OP_MAC);
  assign col_oh   = onehot2(col);
  // A zero pulse width still yields one pulse cycle.
  assign pulse_ld = (pulse == '0) ? '0 : pulse - 1'b1;

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase sequencing and macro strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wl_en    = 2'b00;
    bl_en    = 2'b00;
    sl_en    = 2'b00;
    pre_en   = 1'b0;
    adc_smp  = 1'b0;
    capture  = 1'b0;
    done_evt = 1'b0;
    active   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        active = 1'b1;
        pre_en = rd_op;
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = pulse_ld;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        active = 1'b1;
        if (op == OP_SET)   bl_en = col_oh;
        if (op == OP_RESET) sl_en = col_oh;
        if (cnt_q == '0) begin
          if (rd_op) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        active = 1'b1;
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        active  = 1'b1;
        adc_smp = 1'b1;
        capture = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_evt = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (active) begin
      if (op == OP_MAC) wl_en = 2'b11;
      else              wl_en = onehot2(row);
      if (rd_op)        bl_en = col_oh;
    end
  end

endmodule

// File: tb/tb_rram_wb_seq.sv
// Self-checking bench for rram_wb_seq.
// Sequence model indexed by cycles since start.
module tb_rram_wb_seq;

  localparam int SETUP  = 4;
  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [1:0]  wl;
  logic [1:0]  bl;
  logic [1:0]  sl;
  logic        pre;
  logic        smp;
  logic [3:0]  adc_code = 4'h0;
  logic        busy;
  logic        irq;

  rram_wb_seq dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .wl_en     (wl),
    .bl_en     (bl),
    .sl_en     (sl),
    .pre_en    (pre),
    .adc_smp   (smp),
    .adc_code  (adc_code),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit [1:0]  m_op;
  bit        m_row;
  bit        m_col;
  bit        m_ie;
  bit [7:0]  m_pulse = 8'd1;
  bit        m_done;
  bit        m_err;
  bit [3:0]  m_code;
  bit [15:0] m_seq;
  int        m_k;
  bit        m_bprev;
  bit        rst_q;

  logic        p_we;
  logic [31:0] p_adr;
  logic [31:0] p_dat;
  logic [3:0]  p_sel;

  int n_wl01, n_wl11, n_bl0, n_sl0, n_pre, n_smp;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               nm, got, exp);
    end
  endtask

  function automatic logic [31:0] msk(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}},
            {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] ctrl_word();
    return {22'b0, m_ie, 1'b0, 4'b0,
            m_col, m_row, m_op};
  endfunction

  function automatic logic [31:0] mdl(
    input logic [7:0] off
  );
    case (off)
      8'h00:   return ctrl_word();
      8'h04:   return {24'b0, m_pulse};
      8'h08:   return {29'b0, m_err, m_done, m_bprev};
      8'h0C:   return {m_seq, 12'b0, m_code};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Model update and per-cycle output compare.
  always @(negedge clk) begin : cmp
    logic [31:0] mm;
    logic [31:0] nv;
    logic [31:0] cl;
    logic [1:0]  coh;
    logic [1:0]  e_wl;
    logic [1:0]  e_bl;
    logic [1:0]  e_sl;
    int          p;
    int          l;
    bit          rd_op;
    bit          bsy;
    bit          act;
    bit          in_p;
    bit          e_irq;
    if (rst_q) begin
      m_op = 0; m_row = 0; m_col = 0; m_ie = 0;
      m_pulse = 1; m_done = 0; m_err = 0;
      m_code = 0; m_seq = 0; m_k = 0; m_bprev = 0;
    end else if (ack && p_we &&
                 p_adr[31:8] == 24'h300000) begin
      mm = msk(p_sel);
      case (p_adr[7:0])
        8'h00: begin
          if (m_bprev) m_err = 1;
          else begin
            nv = (ctrl_word() & ~mm) | (p_dat & mm);
            m_op  = nv[1:0];
            m_row = nv[2];
            m_col = nv[3];
`ifdef RRAM_SEQ_IRQ_EN
            m_ie  = nv[9];
`endif
            if (p_dat[8] && mm[8]) begin
              m_k = 1;
              m_done = 0;
            end
          end
        end
        8'h04: begin
          if (m_bprev) m_err = 1;
          else begin
            nv = ({24'b0, m_pulse} & ~mm) |
                 (p_dat & mm);
            m_pulse = nv[7:0];
          end
        end
        8'h08: begin
          cl = p_dat & mm;
          if (cl[1]) m_done = 0;
          if (cl[2]) m_err = 0;
        end
        default: ;
      endcase
    end
    p     = (m_pulse == 0) ? 1 : int'(m_pulse);
    rd_op = (m_op == 0) || (m_op == 3);
    l     = SETUP + p + (rd_op ? SETTLE + 1 : 0) + 1;
    bsy   = (m_k >= 1) && (m_k <= l);
    act   = bsy && (m_k < l);
    in_p  = (m_k > SETUP) && (m_k <= SETUP + p);
    coh   = m_col ? 2'b10 : 2'b01;
    e_wl  = !act ? 2'b00 :
            (m_op == 3) ? 2'b11 :
            (m_row ? 2'b10 : 2'b01);
    e_bl  = ((rd_op && act) ||
             (m_op == 1 && in_p)) ? coh : 2'b00;
    e_sl  = (m_op == 2 && in_p) ? coh : 2'b00;
`ifdef RRAM_SEQ_IRQ_EN
    e_irq = m_done && m_ie;
`else
    e_irq = 1'b0;
`endif
    chk("wl_en", wl, e_wl);
    chk("bl_en", bl, e_bl);
    chk("sl_en", sl, e_sl);
    chk("pre_en", pre, rd_op && act && m_k <= SETUP);
    chk("adc_smp", smp, rd_op && bsy && m_k == l - 1);
    chk("busy", busy, bsy);
    chk("irq", irq, e_irq);
    if (wl == 2'b01) n_wl01++;
    if (wl == 2'b11) n_wl11++;
    if (bl == 2'b01) n_bl0++;
    if (sl == 2'b01) n_sl0++;
    if (pre) n_pre++;
    if (smp) n_smp++;
    if (rd_op && bsy && m_k == l - 1) m_code = adc_code;
    if (bsy && m_k == l) begin
      m_done = 1;
      m_seq++;
    end
    m_bprev = bsy;
    if (m_k > 0) m_k = (m_k == l) ? 0 : m_k + 1;
  end

  task automatic wb(input logic w,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    output logic [31:0] rd,
                    output bit acked);
    int lat;
    acked = 0;
    lat   = 0;
    rd    = '0;
    @(posedge clk);
    #1;
    p_we = w; p_adr = a; p_dat = d; p_sel = s;
    we = w; adr = a; dat = d; sel = s;
    stb = 1; cyc = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1;
        lat   = i;
        rd    = dat_o;
        break;
      end
    end
    @(posedge clk);
    #1;
    stb = 0; cyc = 0; we = 0;
    if (acked) begin
      chk("ack_latency", lat, 1);
      @(negedge clk);
      chk("ack_single", ack, 0);
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] off,
                    input logic [31:0] d);
    logic [31:0] r;
    bit a;
    wb(1, {24'h300000, off}, d, 4'hF, r, a);
    chk("wr_ack", a, 1);
  endtask

  task automatic rd2(input string nm,
                     input logic [7:0] off,
                     input logic [31:0] lit);
    logic [31:0] r;
    bit a;
    wb(0, {24'h300000, off}, 0, 4'hF, r, a);
    chk({nm, "_ack"}, a, 1);
    chk(nm, r, lit);
    chk({nm, "_mdl"}, r, mdl(off));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    chk("idle_timeout", busy, 0);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    bit a;
    int s_a, s_b, s_c;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rd2("rst_ctrl", 8'h00, 32'h0);
    rd2("rst_timing", 8'h04, 32'h1);
    rd2("rst_status", 8'h08, 32'h0);
    rd2("rst_result", 8'h0C, 32'h0);

    wr(8'h04, 32'd5);
    s_a = n_wl01; s_b = n_bl0;
    wr(8'h00, 32'h101);
    wait_idle();
    chk("set_wl01_cyc", n_wl01 - s_a, 9);
    chk("set_bl0_cyc", n_bl0 - s_b, 5);
    rd2("set_status", 8'h08, 32'h2);
    rd2("set_result", 8'h0C, 32'h0001_0000);

    adc_code = 4'hA;
    s_a = n_smp; s_b = n_pre;
    wr(8'h00, 32'h10C);
    wait_idle();
    chk("read_smp_cnt", n_smp - s_a, 1);
    chk("read_pre_cyc", n_pre - s_b, 4);
    rd2("read_result", 8'h0C, 32'h0002_000A);

    adc_code = 4'h3;
    s_c = n_wl11;
    wr(8'h00, 32'h103);
    wait_idle();
    chk("mac_wl11_cyc", n_wl11 - s_c, 18);
    rd2("mac_result", 8'h0C, 32'h0003_0003);

    wr(8'h00, 32'h101);
    wr(8'h00, 32'h101);
    wb(0, 32'h3000_0008, 0, 4'hF, r, a);
    chk("busy_status", r, 32'h5);
    wait_idle();
    rd2("busy_status_end", 8'h08, 32'h6);
    rd2("busy_result", 8'h0C, 32'h0004_0003);
    wr(8'h08, 32'h6);
    rd2("w1c_status", 8'h08, 32'h0);

    wr(8'h04, 32'd0);
    rd2("t0_timing", 8'h04, 32'h0);
    s_a = n_sl0;
    wr(8'h00, 32'h102);
    wait_idle();
    chk("t0_sl0_cyc", n_sl0 - s_a, 1);
    rd2("t0_result", 8'h0C, 32'h0005_0003);

    wr(8'h04, 32'd5);
    wr(8'h00, 32'h101);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bl == 2'b00 && n < 30);
    chk("pulse_seen", bl, 2'b01);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    rd2("mid_rst_status", 8'h08, 32'h0);
    rd2("mid_rst_result", 8'h0C, 32'h0);
    rd2("mid_rst_timing", 8'h04, 32'h1);

    wb(0, 32'h3000_0100, 0, 4'hF, r, a);
    chk("oob_ack_hi", a, 0);
    wb(0, 32'h2000_0000, 0, 4'hF, r, a);
    chk("oob_ack_lo", a, 0);
    wb(0, 32'h3000_0010, 0, 4'hF, r, a);
    chk("unmapped_ack", a, 1);
    chk("unmapped_data", r, 32'h0);

    wb(1, 32'h3000_0004, 32'hFF, 4'b0010, r, a);
    rd2("lane_timing", 8'h04, 32'h1);
    wb(1, 32'h3000_0000, 32'h1FF, 4'b0001, r, a);
    rd2("lane_ctrl", 8'h00, 32'hF);

    wr(8'h00, 32'h200);
`ifdef RRAM_SEQ_IRQ_EN
    rd2("irqen_ctrl", 8'h00, 32'h200);
`else
    rd2("irqen_ctrl", 8'h00, 32'h0);
`endif
    wr(8'h00, 32'h301);
    wait_idle();
`ifdef RRAM_SEQ_IRQ_EN
    chk("irq_rise", irq, 1);
    wr(8'h08, 32'h2);
    chk("irq_clear", irq, 0);
`else
    chk("irq_tied", irq, 0);
    wr(8'h08, 32'h2);
    chk("irq_tied_after", irq, 0);
`endif
    rd2("final_status", 8'h08, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
